// File: rtl/iic_xfer_seq.sv
// Transaction sequencer in front of the iic_rw byte engine: buffers write payload,
// launches the engine, forwards read bytes, retries on error. Optional ack polling: IIC_ACKPOLL_EN.
module iic_xfer_seq #(
   parameter int ADDRWIDTH = 16,
   parameter int NUMWIDTH  = 6,
   parameter int MAX_RETRY = 3,
   parameter int RETRY_GAP = 64
) (
   input  logic                 I_clk,
   input  logic                 I_rst,
   input  logic                 I_req,
   input  logic                 I_req_rw,
   input  logic [6:0]           I_req_dev,
   input  logic [ADDRWIDTH-1:0] I_req_addr,
   input  logic [NUMWIDTH-1:0]  I_req_num,
   output logic                 O_req_ack,
   input  logic [7:0]           I_wdata,
   input  logic                 I_wvalid,
   output logic                 O_wready,
   output logic [7:0]           O_rdata,
   output logic                 O_rvalid,
   output logic                 O_done,
   output logic                 O_fail,
   output logic                 O_busy,
   output logic [6:0]           O_device,
   output logic [ADDRWIDTH-1:0] O_addr,
   output logic [NUMWIDTH-1:0]  O_num,
   output logic                 O_rw,
   output logic                 O_start,
   output logic [7:0]           O_databyte,
   input  logic                 I_busy,
   input  logic                 I_nextdata,
   input  logic [7:0]           I_databyte,
   input  logic                 I_datavalid,
   input  logic                 I_error
);
   localparam int DEPTH = 1 << NUMWIDTH;
   localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW    = 16;

   typedef enum logic [3:0] {
      S_IDLE, S_FILL, S_LAUNCH, S_WAITB, S_RUN, S_ERR, S_GAP, S_DONE, S_FAIL
`ifdef IIC_ACKPOLL_EN
      , S_PGAP, S_PLAUNCH, S_PWAIT, S_PRUN
`endif
   } state_t;

   state_t                state, state_nxt;
   logic [7:0]            mem [DEPTH];
   logic [NUMWIDTH-1:0]   wr_ptr, rd_ptr, snap_ptr, rd_nxt;
   logic [NUMWIDTH:0]     count, snap_cnt;
   logic [RW-1:0]         retry;
   logic [TW-1:0]         tmr;
   logic [6:0]            dev;
   logic [ADDRWIDTH-1:0]  addr;
   logic [NUMWIDTH-1:0]   num;
   logic                  rw, ack, rvalid;
   logic [7:0]            rdata, databyte;
   logic                  push, pop, clear, rewind;
`ifdef IIC_ACKPOLL_EN
   logic [8:0]            probes;
`endif

   assign push   = I_wvalid & O_wready;
   assign pop    = I_nextdata & (count != '0);
   assign clear  = (state == S_DONE) || (state == S_FAIL);
   assign rewind = (state == S_ERR);

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (I_req) state_nxt = (I_req_num == '0) ? S_DONE : (I_req_rw ? S_LAUNCH : S_FILL);
         S_FILL:   if (count == {1'b0, num}) state_nxt = S_LAUNCH;
         S_LAUNCH: state_nxt = S_WAITB;
         S_WAITB:  if (I_busy) state_nxt = S_RUN;
                   else if (tmr == TW'(3)) state_nxt = S_ERR;
         S_RUN: begin
            if (I_error) state_nxt = S_ERR;
            else if (!I_busy) begin
`ifdef IIC_ACKPOLL_EN
               state_nxt = rw ? S_DONE : S_PGAP;
`else
               state_nxt = S_DONE;
`endif
            end
         end
         S_ERR:    state_nxt = (retry == RW'(MAX_RETRY)) ? S_FAIL : S_GAP;
         S_GAP:    if (tmr == TW'(RETRY_GAP - 1)) state_nxt = S_LAUNCH;
         S_DONE:   state_nxt = S_IDLE;
         S_FAIL:   state_nxt = S_IDLE;
`ifdef IIC_ACKPOLL_EN
         S_PGAP:   if (tmr == TW'(RETRY_GAP - 1)) state_nxt = (probes == 9'd256) ? S_FAIL : S_PLAUNCH;
         S_PLAUNCH: state_nxt = S_PWAIT;
         // a probe that never raises busy counts as a failed probe
         S_PWAIT:  if (I_busy) state_nxt = S_PRUN;
                   else if (tmr == TW'(3)) state_nxt = S_PGAP;
         S_PRUN:   if (I_error) state_nxt = S_PGAP;
                   else if (!I_busy) state_nxt = S_DONE;
`endif
         default:  state_nxt = S_IDLE;
      endcase
   end

   // shared timer restarts on every state change (WAITB timeout, retry gap)
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) tmr <= '0;
      else       tmr <= (state_nxt != state) ? '0 : tmr + TW'(1);
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         dev <= '0; addr <= '0; num <= '0; rw <= 1'b0;
         ack <= 1'b0; rvalid <= 1'b0; rdata <= '0; retry <= '0;
`ifdef IIC_ACKPOLL_EN
         probes <= '0;
`endif
      end else begin
         ack    <= (state == S_IDLE) && I_req;
         rvalid <= (state == S_RUN) && I_datavalid;
         if (I_datavalid) rdata <= I_databyte;
         if (state == S_IDLE && I_req) begin
            dev <= I_req_dev; addr <= I_req_addr; num <= I_req_num; rw <= I_req_rw;
         end
         if (state == S_ERR && state_nxt == S_GAP) retry <= retry + RW'(1);
         else if (clear)                           retry <= '0;
`ifdef IIC_ACKPOLL_EN
         if (state == S_RUN && state_nxt == S_PGAP) num <= '0;
         if (state == S_RUN)          probes <= '0;
         else if (state == S_PLAUNCH) probes <= probes + 9'd1;
`endif
      end
   end

   always_comb begin
      rd_nxt = rd_ptr;
      if (clear)       rd_nxt = '0;
      else if (rewind) rd_nxt = snap_ptr;
      else if (pop)    rd_nxt = rd_ptr + NUMWIDTH'(1);
   end

   always_ff @(posedge I_clk) begin
      if (push) mem[wr_ptr] <= I_wdata;
   end

   // head register looks ahead at the next read pointer so a pop shows the new head next cycle
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         wr_ptr <= '0; rd_ptr <= '0; count <= '0;
         snap_ptr <= '0; snap_cnt <= '0; databyte <= '0;
      end else begin
         databyte <= (push && wr_ptr == rd_nxt) ? I_wdata : mem[rd_nxt];
         rd_ptr   <= rd_nxt;
         if (clear) begin
            wr_ptr <= '0; count <= '0;
         end else if (rewind) begin
            count <= snap_cnt;
         end else begin
            if (push) wr_ptr <= wr_ptr + NUMWIDTH'(1);
            count <= count + {{NUMWIDTH{1'b0}}, push} - {{NUMWIDTH{1'b0}}, pop};
         end
         if (state == S_LAUNCH) begin
            snap_ptr <= rd_ptr; snap_cnt <= count;
         end
      end
   end

   assign O_wready   = (state == S_FILL) && (count < {1'b0, num});
   assign O_busy     = (state != S_IDLE);
   assign O_done     = (state == S_DONE);
   assign O_fail     = (state == S_FAIL);
`ifdef IIC_ACKPOLL_EN
   assign O_start    = (state == S_LAUNCH) || (state == S_PLAUNCH);
`else
   assign O_start    = (state == S_LAUNCH);
`endif
   assign O_req_ack  = ack;
   assign O_rdata    = rdata;
   assign O_rvalid   = rvalid;
   assign O_device   = dev;
   assign O_addr     = addr;
   assign O_num      = num;
   assign O_rw       = rw;
   assign O_databyte = databyte;
endmodule

// File: doc/iic_xfer_seq.md
Name: iic_xfer_seq

Overview:
- Transaction sequencer directly upstream of the I2C byte-level read/write engine (iic_rw).
- Accepts one host request (device, address, byte count, direction), buffers write bytes in an internal FIFO, and launches the engine only once the whole payload is present.
- Serves the engine's per-byte data requests, returns read bytes to the host as a valid stream, and retries the whole transaction after an engine error (NACK).
- Runs on the same I2C-rate clock as the engine.

Parameters:
ADDRWIDTH, 16, width of memory address passed to the engine
NUMWIDTH, 6, width of byte count; legal count 0..2^NUMWIDTH-1
MAX_RETRY, 3, engine restarts allowed after an error before failing
RETRY_GAP, 64, idle cycles between an error and the next restart (minimum 1)

Ports:
I_clk  in  1  clock, same as engine
I_rst  in  1  asynchronous active-high reset
I_req  in  1  request strobe, sampled only in IDLE
I_req_rw  in  1  0 = write, 1 = read
I_req_dev  in  7  7-bit device address
I_req_addr  in  ADDRWIDTH  memory address
I_req_num  in  NUMWIDTH  byte count
O_req_ack  out  1  one-cycle pulse when a request is latched
I_wdata  in  8  host write byte
I_wvalid  in  1  write byte valid
O_wready  out  1  FIFO not full and state is FILL
O_rdata  out  8  read byte to host
O_rvalid  out  1  one-cycle pulse per read byte
O_done  out  1  one-cycle pulse on successful completion
O_fail  out  1  one-cycle pulse when retries are exhausted
O_busy  out  1  high in every state except IDLE
O_device  out  7  to engine, latched I_req_dev
O_addr  out  ADDRWIDTH  to engine, latched I_req_addr
O_num  out  NUMWIDTH  to engine, latched I_req_num
O_rw  out  1  to engine, latched I_req_rw
O_start  out  1  to engine, one-cycle start pulse
O_databyte  out  8  to engine, current FIFO head
I_busy  in  1  engine busy
I_nextdata  in  1  engine consumed O_databyte; pulse
I_databyte  in  8  byte read by engine
I_datavalid  in  1  I_databyte valid; pulse
I_error  in  1  engine NACK/error; pulse

Behaviour:
- Reset (asynchronous, any state):
  - All outputs 0; state IDLE; FIFO pointers 0; retry counter 0.
  - Any transaction in progress is abandoned immediately, with no O_fail or O_done pulse.
- FIFO:
  - Depth 2^NUMWIDTH, 8 bits wide; push on I_wvalid & O_wready.
  - Pointers wrap modulo depth; count register is NUMWIDTH+1 bits wide.
  - O_databyte is the head entry, registered, and valid before O_start.
  - I_nextdata pops the FIFO; the new head appears the next cycle.
  - For retries the FIFO keeps a snapshot read pointer taken at launch; each restart rewinds the read pointer to it so the same payload is resent.
- IDLE:
  - On I_req: latch all request fields, pulse O_req_ack.
  - I_req_num == 0: go to DONE (no bus traffic).
  - Write: go to FILL. Read: go to LAUNCH.
- FILL:
  - O_wready = (count < I_req_num).
  - Go to LAUNCH the cycle after count == latched num.
  - Bytes presented while O_wready = 0 are ignored.
- LAUNCH:
  - Assert O_start for 1 cycle, then go to WAITB.
- WAITB:
  - Wait for I_busy = 1, then go to RUN.
  - If I_busy stays 0 for 4 cycles, treat it as an error (go to ERR).
- RUN:
  - Read: each I_datavalid produces O_rdata = I_databyte with O_rvalid = 1 the next cycle.
  - I_error at any time: go to ERR.
  - I_busy falling with no error: go to DONE.
- ERR:
  - If retry counter == MAX_RETRY: go to FAIL.
  - Otherwise: increment retry counter, rewind FIFO, count RETRY_GAP cycles, then go to LAUNCH.
  - Read bytes already delivered to the host on a failed attempt are not recalled. The host must discard all read bytes of a transaction that ends in O_fail.
- DONE:
  - Pulse O_done, clear retry counter and FIFO, return to IDLE.
- FAIL:
  - Pulse O_fail, clear retry counter and FIFO, return to IDLE.
- Simultaneous events:
  - I_error together with I_datavalid in the same cycle: the data byte is still forwarded, then ERR.
  - I_error together with I_busy falling: error wins.
  - I_nextdata while the FIFO is empty: no pop, O_databyte is held.

Optional Feature:
- Macro IIC_ACKPOLL_EN.
- Defined:
  - After a successful write, go to POLL instead of DONE.
  - POLL issues an address-only probe (O_rw = 0, O_num = 0, O_start pulse) every RETRY_GAP cycles until a probe completes without I_error; then go to DONE.
  - Polling is capped at 256 probes; exceeding the cap goes to FAIL.
  - Read transactions are unaffected.
- Not defined:
  - POLL logic is absent; a successful write goes straight to DONE.

Test Plan:
- Write dev 0x50, addr 0x0000, num 4, bytes 4C,4D,4E,4F; engine model acks all -> O_start exactly once after the 4th push; engine receives 4C..4F in order; O_done one pulse; O_fail never.
- Read num 3; model returns A1,B2,C3 -> O_rvalid three pulses with O_rdata A1,B2,C3; then O_done.
- Write num 2; model errors on the first attempt, succeeds on the second -> two O_start pulses separated by at least RETRY_GAP cycles; payload resent identically; O_done.
- Model errors on every attempt -> MAX_RETRY+1 O_start pulses total; then O_fail; O_busy falls.
- Request with num 0 -> O_req_ack then O_done; no O_start.
- Assert I_rst during RUN -> all outputs 0 the same cycle; next request behaves as after power-up.
